// File: rtl/slot_display_driver.sv
// Six-digit active-low seven-segment driver: reel symbols and bet go through a registered decode,
// credits go through a double-dabble engine (12 cycles from sample to digits).
module slot_display_driver #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] symbol_left,
  input  logic [2:0] symbol_right,
  input  logic [9:0] current_credits,
  input  logic [3:0] current_bet,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       busy,
  output logic       conv_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'h40;
      4'd1:    seg_digit = 7'h79;
      4'd2:    seg_digit = 7'h24;
      4'd3:    seg_digit = 7'h30;
      4'd4:    seg_digit = 7'h19;
      4'd5:    seg_digit = 7'h12;
      4'd6:    seg_digit = 7'h02;
      4'd7:    seg_digit = 7'h78;
      4'd8:    seg_digit = 7'h00;
      4'd9:    seg_digit = 7'h10;
      default: seg_digit = SEG_DASH;
    endcase
  endfunction

  function automatic logic [6:0] seg_symbol(input logic [2:0] s);
    case (s)
      3'd0:    seg_symbol = 7'h78;
      3'd1:    seg_symbol = 7'h46;
      3'd2:    seg_symbol = 7'h36;
      3'd3:    seg_symbol = 7'h2C;
      default: seg_symbol = SEG_DASH;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  snap_q, snap_d;
  logic        snap_valid_q, snap_valid_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  hex2_q, hex2_d, hex1_q, hex1_d, hex0_q, hex0_d;
  logic [6:0]  hex5_q, hex4_q, hex3_q;
  logic        done_q, done_d;
  logic [11:0] bcd_adj;
  logic [9:0]  credits_sat;

  assign credits_sat = (current_credits > 10'd999) ? 10'd999 : current_credits;
  assign bcd_adj     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    bcd_d        = bcd_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    hex2_d       = hex2_q;
    hex1_d       = hex1_q;
    hex0_d       = hex0_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // snap keeps the raw input so a saturated value does not retrigger forever
        if (!snap_valid_q || current_credits != snap_q) begin
          snap_d  = current_credits;
          shreg_d = credits_sat;
          bcd_d   = '0;
          cnt_d   = 4'd10;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj[10:0], shreg_q, 1'b0};
        cnt_d            = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = LOAD;
      end
      LOAD: begin
        hex2_d = (BLANK_LEADING && bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg_digit(bcd_q[11:8]);
        hex1_d = (BLANK_LEADING && bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg_digit(bcd_q[7:4]);
        hex0_d       = seg_digit(bcd_q[3:0]);
        snap_valid_d = 1'b1;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      bcd_q        <= '0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      hex2_q       <= SEG_BLANK;
      hex1_q       <= SEG_BLANK;
      hex0_q       <= SEG_BLANK;
      hex5_q       <= SEG_BLANK;
      hex4_q       <= SEG_BLANK;
      hex3_q       <= SEG_BLANK;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      bcd_q        <= bcd_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      hex2_q       <= hex2_d;
      hex1_q       <= hex1_d;
      hex0_q       <= hex0_d;
      hex5_q       <= seg_symbol(symbol_left);
      hex4_q       <= seg_symbol(symbol_right);
      hex3_q       <= seg_digit(current_bet);
      done_q       <= done_d;
    end
  end

  assign hex5      = hex5_q;
  assign hex4      = hex4_q;
  assign hex3      = hex3_q;
  assign hex2      = hex2_q;
  assign hex1      = hex1_q;
  assign hex0      = hex0_q;
  assign busy      = (state_q != IDLE);
  assign conv_done = done_q;

endmodule

// File: doc/slot_display_driver.md
# slot_display_driver

Display-side consumer of the slot machine controller's outputs: takes `symbol_left`, `symbol_right`, `current_credits` and `current_bet` and drives six active-low seven-segment digits. Credits (binary, 0–999) are converted to BCD with an iterative shift-add-3 (double-dabble) engine that re-runs whenever the credit value changes. Symbols and bet are decoded to glyphs with a one-cycle registered path.

## Interface
Parameters:
- `BLANK_LEADING`, 1, when 1 suppress leading zeros on the credit digits; when 0 show all three.

Ports:
- `clk`  in  1  system clock (50 MHz board clock).
- `reset`  in  1  asynchronous, active-high reset.
- `symbol_left`  in  3  left reel symbol (0 SEVEN, 1 CHERRY, 2 BAR, 3 QUEST).
- `symbol_right`  in  3  right reel symbol, same encoding.
- `current_credits`  in  10  wallet balance, binary.
- `current_bet`  in  4  active bet, binary.
- `hex5`, `hex4`  out  7 each  left and right symbol glyphs.
- `hex3`  out  7  bet digit.
- `hex2`, `hex1`, `hex0`  out  7 each  credit hundreds, tens, units.
- `busy`  out  1  high while a credit conversion is in progress.
- `conv_done`  out  1  one-cycle pulse when new credit digits are written.

## Operation
- Segment format, all outputs: `{g,f,e,d,c,b,a}`, active-low (0 = lit).
- Digits 0–9: 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10. Blank 0x7F. Dash 0x3F.
- Symbol glyphs: SEVEN 0x78, CHERRY ('C') 0x46, BAR (a,d,g) 0x36, QUEST ('?') 0x2C. Symbol codes 4–7 show dash.
- Bet: values 0–9 show the digit. Values 10–15 show dash.
- Credit snapshot register `snap` (10 b) plus a `snap_valid` flag. Conversion FSM:
  - IDLE: if `!snap_valid` or `current_credits != snap`, load `snap <= current_credits`, clear the 12-bit BCD accumulator, set the bit count to 10, go to SHIFT, and raise `busy`.
  - SHIFT: each cycle, first add 3 to every BCD nibble that is ≥5, then shift `{bcd, shreg}` left by 1. After 10 cycles go to LOAD.
  - LOAD: decode the accumulator into `hex2..hex0`, all three on the same edge. Set `snap_valid <= 1`, pulse `conv_done`, drop `busy`, return to IDLE.
- Inputs above 999 (1000–1023) saturate: `snap` is converted as 999.
- Leading-zero blanking (BLANK_LEADING=1):
  - hundreds = 0 → `hex2` blank.
  - hundreds = 0 and tens = 0 → `hex1` blank.
  - `hex0` is always shown, so 0 displays as a single "0".
- A credit change during SHIFT or LOAD is ignored by the running conversion. The FSM finishes with the old snapshot, then detects the mismatch in IDLE and restarts. The display never shows a torn mix of old and new digits.

## Timing
- Reset values: `hex0..hex5` = 0x7F, `busy` = 0, `conv_done` = 0, `snap_valid` = 0, FSM in IDLE.
- Symbol and bet paths: output valid 1 clock after the input changes. They update every cycle, independent of the FSM, including while `busy`.
- Credit path latency, from the IDLE edge that samples a new value:
  - 1 edge to enter SHIFT.
  - 10 SHIFT edges.
  - 1 LOAD edge.
  - `hex2..hex0` and `conv_done` change on the 12th edge after sampling.
- `busy` is high for exactly 11 cycles per conversion (SHIFT×10 + LOAD). It falls on the same edge `conv_done` rises.
- First conversion starts on the first rising edge after reset deasserts.
- Back-to-back: with the input changing continuously, the minimum spacing between `conv_done` pulses is 12 cycles.
- Reset asserted mid-conversion: all state and outputs return to reset values immediately (asynchronously). The partial result is discarded.

## Test plan
- Reset, then hold credits=100, bet=1, symbols 0/1 → within 13 clocks: `hex2`=0x79, `hex1`=0x40, `hex0`=0x40, `hex3`=0x79, `hex5`=0x78, `hex4`=0x46, and exactly one `conv_done` pulse.
- Credits 999 → 7 → 0 with BLANK_LEADING=1 → "999" = 0x10/0x10/0x10; "7" = 0x7F/0x7F/0x78; "0" = 0x7F/0x7F/0x40. With BLANK_LEADING=0, "7" shows 0x40/0x40/0x78.
- Credits change 250→251 on the 3rd cycle of SHIFT → 250 is displayed first, then 251 twelve cycles later. Never a mixed value, and two `conv_done` pulses.
- Credits 1023 → displayed "999". Symbol code 5 and bet 12 → 0x3F on the affected digits.
- Assert reset on the 6th SHIFT cycle → all outputs 0x7F and `busy`=0 in the same cycle. After release, the conversion of the current input completes 12 edges later.
- Symbol sweep 0–3 on both reels while `busy`=1 → `hex5`/`hex4` follow each input 1 cycle later with glyphs 0x78, 0x46, 0x36, 0x2C.
